// File: rtl/controle_preparo_pkg.sv
// rtl/controle_preparo_pkg.sv - shared codes and state encoding for the brew controller and sensor monitor
package controle_preparo_pkg;

    typedef logic [1:0] status_t;
    typedef logic [3:0] codigo_t;

    // 3'b111 is unused and recovers to OCIOSO.
    typedef enum logic [2:0] {
        OCIOSO          = 3'd0,
        AGUARDA_ANALISE = 3'd1,
        ESPERA_CORRECAO = 3'd2,
        AQUECENDO       = 3'd3,
        BOMBEANDO       = 3'd4,
        CONCLUIDO       = 3'd5,
        BLOQUEADO       = 3'd6
    } estado_t;

    localparam status_t ST_ANALISANDO   = 2'b00;
    localparam status_t ST_ERRO         = 2'b01;
    localparam status_t ST_OK           = 2'b10;
    localparam status_t ST_FALHA_SENSOR = 2'b11;

    localparam codigo_t ERR_AGUA    = 4'b0101;
    localparam codigo_t ERR_CAPSULA = 4'b0110;
    localparam codigo_t ERR_COPO    = 4'b0111;

    localparam codigo_t DISP_NADA   = 4'b0000;
    localparam codigo_t DISP_AQUEC  = 4'b0001;
    localparam codigo_t DISP_BOMBA  = 4'b0010;
    localparam codigo_t DISP_PRONTO = 4'b0011;
    localparam codigo_t DISP_FALHA  = 4'b1111;

    // A phase of N cycles loads N-1 so that the zero flag marks its last cycle.
    function automatic logic [7:0] carga_fase(input int unsigned ciclos);
        logic [7:0] c;
        c = ciclos[7:0];
        return c - 8'd1;
    endfunction

endpackage

// File: rtl/controle_preparo_if.sv
// rtl/controle_preparo_if.sv - user/sensor-monitor side signals of the brew controller
// master: sensor monitor / user side (drives START, STATUS, ERR_CODE)
// slave : controle_preparo (drives TIMER, AQUECEDOR, BOMBA, DISPLAY, PRONTO, FALHA)
interface controle_preparo_if;
    import controle_preparo_pkg::*;

    logic    START;
    status_t STATUS;
    codigo_t ERR_CODE;
    logic    TIMER;
    logic    AQUECEDOR;
    logic    BOMBA;
    codigo_t DISPLAY;
    logic    PRONTO;
    logic    FALHA;

    modport master (
        output START, STATUS, ERR_CODE,
        input  TIMER, AQUECEDOR, BOMBA, DISPLAY, PRONTO, FALHA
    );

    modport slave (
        input  START, STATUS, ERR_CODE,
        output TIMER, AQUECEDOR, BOMBA, DISPLAY, PRONTO, FALHA
    );
endinterface

// File: rtl/controle_preparo_contador.sv
// rtl/controle_preparo_contador.sv - 8-bit saturating down counter with load and zero flag
// Ports: CLK, RESET_N (sync, active low), load/load_val, enable, value, zero.
module contador_regressivo (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       load,
    input  logic       enable,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       zero
);
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            value <= 8'd0;
        end else if (load) begin
            value <= load_val;
        end else if (enable && value != 8'd0) begin
            value <= value - 8'd1;
        end
    end

    assign zero = (value == 8'd0);
endmodule

// File: rtl/controle_preparo.sv
// rtl/controle_preparo.sv - coffee brew controller: sensor check, correction window, heat, pump
// Ports: CLK, RESET_N (sync, active low), bus (controle_preparo_if.slave):
//   START, STATUS, ERR_CODE in; TIMER, AQUECEDOR, BOMBA, DISPLAY, PRONTO, FALHA out.
// Moore FSM; every output is registered from the next state on the state edge.
module controle_preparo
    import controle_preparo_pkg::*;
#(
    parameter int unsigned T_ERRO  = 10,
    parameter int unsigned T_AQUEC = 8,
    parameter int unsigned T_BOMBA = 6
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    controle_preparo_if.slave    bus
);
    localparam logic [7:0] CARGA_ERRO  = 8'(T_ERRO);
    localparam logic [7:0] CARGA_AQUEC = carga_fase(T_AQUEC);
    localparam logic [7:0] CARGA_BOMBA = carga_fase(T_BOMBA);

    estado_t    estado, nxt;
    logic       cnt_load, cnt_en, cnt_zero;
    logic [7:0] cnt_carga, cnt;
    codigo_t    err_ant;
    logic       timer_n;
    codigo_t    disp_n;

    contador_regressivo u_contador (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .load     (cnt_load),
        .enable   (cnt_en),
        .load_val (cnt_carga),
        .value    (cnt),
        .zero     (cnt_zero)
    );

    always_comb begin
        nxt       = estado;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cnt_carga = 8'd0;
        timer_n   = 1'b0;
        case (estado)
            OCIOSO: begin
                if (bus.START) nxt = AGUARDA_ANALISE;
            end
            AGUARDA_ANALISE: begin
                case (bus.STATUS)
                    ST_OK:           begin nxt = AQUECENDO; cnt_load = 1'b1; cnt_carga = CARGA_AQUEC; end
                    ST_ERRO:         begin nxt = ESPERA_CORRECAO; cnt_load = 1'b1; cnt_carga = CARGA_ERRO; end
                    ST_FALHA_SENSOR: nxt = BLOQUEADO;
                    default:         nxt = AGUARDA_ANALISE;
                endcase
            end
            ESPERA_CORRECAO: begin
                if (bus.STATUS == ST_OK) begin
                    nxt       = AQUECENDO;
                    cnt_load  = 1'b1;
                    cnt_carga = CARGA_AQUEC;
                end else if (bus.STATUS == ST_FALHA_SENSOR) begin
                    nxt = BLOQUEADO;
                end else if (bus.STATUS == ST_ERRO && bus.ERR_CODE != err_ant) begin
                    // A different error gets a fresh window; TIMER drops with the reload.
                    cnt_load  = 1'b1;
                    cnt_carga = CARGA_ERRO;
                end else begin
                    cnt_en  = 1'b1;
                    // Registered together with the counter reaching 0, so TIMER
                    // shows T_ERRO cycles after the window opened and then holds.
                    timer_n = (cnt <= 8'd1);
                end
            end
            AQUECENDO: begin
                if (bus.STATUS == ST_FALHA_SENSOR) begin
                    nxt = BLOQUEADO;
                end else if (cnt_zero) begin
                    nxt       = BOMBEANDO;
                    cnt_load  = 1'b1;
                    cnt_carga = CARGA_BOMBA;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            BOMBEANDO: begin
                if (bus.STATUS == ST_FALHA_SENSOR) nxt = BLOQUEADO;
                else if (cnt_zero)                 nxt = CONCLUIDO;
                else                               cnt_en = 1'b1;
            end
            CONCLUIDO: nxt = OCIOSO;
            BLOQUEADO: nxt = BLOQUEADO;
            default:   nxt = OCIOSO;
        endcase

        case (nxt)
            ESPERA_CORRECAO: disp_n = bus.ERR_CODE;
            AQUECENDO:       disp_n = DISP_AQUEC;
            BOMBEANDO:       disp_n = DISP_BOMBA;
            CONCLUIDO:       disp_n = DISP_PRONTO;
            BLOQUEADO:       disp_n = DISP_FALHA;
            default:         disp_n = DISP_NADA;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            estado        <= OCIOSO;
            err_ant       <= 4'd0;
            bus.TIMER     <= 1'b0;
            bus.AQUECEDOR <= 1'b0;
            bus.BOMBA     <= 1'b0;
            bus.PRONTO    <= 1'b0;
            bus.FALHA     <= 1'b0;
            bus.DISPLAY   <= DISP_NADA;
        end else begin
            estado        <= nxt;
            err_ant       <= bus.ERR_CODE;
            bus.TIMER     <= timer_n;
            bus.AQUECEDOR <= (nxt == AQUECENDO);
            bus.BOMBA     <= (nxt == BOMBEANDO);
            bus.PRONTO    <= (nxt == CONCLUIDO);
            bus.FALHA     <= (nxt == BLOQUEADO);
            bus.DISPLAY   <= disp_n;
        end
    end
endmodule

// File: doc/controle_preparo.md
CONTROLE_PREPARO -- requirements
Module: controle_preparo

Interface
REQ-001 Parameter T_ERRO, default 10, cycles allowed for the user to correct a reported sensor error before TIMER asserts; legal range 1..255.
REQ-002 Parameter T_AQUEC, default 8, heating duration in cycles; legal range 1..255.
REQ-003 Parameter T_BOMBA, default 6, pumping duration in cycles; legal range 1..255.
REQ-004 CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 RESET_N  input  1  synchronous, active-low reset.
REQ-006 START  input  1  user brew request, level-sampled.
REQ-007 STATUS  input  2  sensor-monitor status: 00 analysing, 01 error, 10 no errors, 11 sensor fault.
REQ-008 ERR_CODE  input  4  sensor-monitor error code: 0101 water, 0110 capsule, 0111 cup.
REQ-009 TIMER  output  1  correction-window expired, returned to the sensor monitor.
REQ-010 AQUECEDOR  output  1  heater enable.
REQ-011 BOMBA  output  1  pump enable.
REQ-012 DISPLAY  output  4  code shown to the user.
REQ-013 PRONTO  output  1  one-cycle pulse marking a completed brew.
REQ-014 FALHA  output  1  permanent fault indicator.

Function
REQ-015 The block SHALL be a Moore FSM with registered outputs, updated on the same edge as the state register.
REQ-016 The FSM SHALL have the states OCIOSO, AGUARDA_ANALISE, ESPERA_CORRECAO, AQUECENDO, BOMBEANDO, CONCLUIDO and BLOQUEADO.
REQ-017 In OCIOSO, START=1 SHALL move the FSM to AGUARDA_ANALISE on the next edge; START SHALL be ignored in every other state.
REQ-018 In AGUARDA_ANALISE:
- STATUS=00 holds the state.
- STATUS=10 goes to AQUECENDO.
- STATUS=01 goes to ESPERA_CORRECAO and loads the counter with T_ERRO.
- STATUS=11 goes to BLOQUEADO.
REQ-019 In ESPERA_CORRECAO:
- DISPLAY=ERR_CODE.
- The counter decrements once per cycle, saturating at 0.
- TIMER=1 from the cycle after the counter reaches 0 until the state is left.
REQ-020 In ESPERA_CORRECAO, a change of ERR_CODE while STATUS=01 SHALL reload T_ERRO and clear TIMER, giving a new error a full window.
REQ-021 In ESPERA_CORRECAO:
- STATUS=10 goes to AQUECENDO.
- STATUS=11 goes to BLOQUEADO.
- If both occur in the same cycle as counter expiry, the STATUS transition wins.
REQ-022 In AQUECENDO, AQUECEDOR=1 and DISPLAY=0001 for exactly T_AQUEC cycles, then the FSM goes to BOMBEANDO.
REQ-023 In BOMBEANDO, BOMBA=1 and DISPLAY=0010 for exactly T_BOMBA cycles, then the FSM goes to CONCLUIDO.
REQ-024 In AQUECENDO or BOMBEANDO, STATUS=11 SHALL abort immediately to BLOQUEADO, and AQUECEDOR and BOMBA SHALL both be 0 on the following cycle.
REQ-025 CONCLUIDO SHALL last one cycle with PRONTO=1 and DISPLAY=0011, then the FSM returns to OCIOSO.
REQ-026 BLOQUEADO SHALL hold FALHA=1 and DISPLAY=1111 with all other outputs 0, and SHALL exit only through reset.
REQ-027 AQUECEDOR and BOMBA SHALL never be 1 in the same cycle.
REQ-028 In OCIOSO and AGUARDA_ANALISE, DISPLAY SHALL be 0000.
REQ-029 The counter SHALL be 8 bits, unsigned, and SHALL never wrap below 0.
REQ-030 Unused state encodings SHALL recover to OCIOSO on the next edge.

Reset
REQ-031 RESET_N=0 at a rising edge SHALL force:
- the FSM to OCIOSO;
- the counter to 0;
- TIMER, AQUECEDOR, BOMBA, PRONTO and FALHA to 0;
- DISPLAY to 0000.
REQ-032 Reset SHALL take priority over START and STATUS, including mid-heating and mid-pumping, with the outputs off on the following cycle.

Structure
REQ-033 STATUS codes, ERR_CODE values, DISPLAY codes and state encodings SHALL live in a shared package used by this block and by the sensor monitor.
REQ-034 The cycle counter SHALL be one sub-module, contador_regressivo, with load, enable, 8-bit value and zero flag.

Verification
REQ-035 Happy path: reset, then START=1 for one cycle, then STATUS=10 -> AQUECEDOR high 8 cycles, then BOMBA high 6 cycles, then PRONTO high 1 cycle, then OCIOSO.
REQ-036 Timeout: STATUS=01, ERR_CODE=0110 held -> DISPLAY=0110; TIMER rises 10 cycles after entry and stays high; then STATUS=11 -> FALHA=1, DISPLAY=1111.
REQ-037 Correction: STATUS=01 for 4 cycles, then 10 -> TIMER never asserts, heating starts.
REQ-038 Code change: ERR_CODE goes 0101 to 0111 at cycle 7 of the window -> TIMER asserts 10 cycles after the change, not at cycle 10.
REQ-039 Reset mid-pump: RESET_N=0 during BOMBEANDO cycle 3 -> BOMBA=0 next cycle, DISPLAY=0000, and a new START brews normally.
REQ-040 Abort and ignore: STATUS=11 during AQUECENDO -> AQUECEDOR=0 next cycle and BLOQUEADO; START pulses in BLOQUEADO cause no change.
